dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 36 +++
 rtl/dmem_arb_prio.sv | 61 ++++++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and defaults for the data-memory arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, READ_WAIT)
//   - arb_port_e  : requester identity (PORT_CPU, PORT_DMA)
//   - MAX_CPU_RUN_DEFAULT : default limit on consecutive CPU grants while
//     the DMA port is waiting
//   - RUN_CNT_BITS : width of the CPU run counter (covers limits 1..15)
//
//   The address/data width macros normally come from data_memory's
//   macros.vh. The guarded fallbacks below keep this slice self-contained.
//   An earlier definition always takes precedence.
// ----------------------------------------------------------------------------
`ifndef A_BITS
`define A_BITS 8
`endif
`ifndef D_BITS
`define D_BITS 8
`endif

package dmem_arb_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } arb_port_e;

    localparam int MAX_CPU_RUN_DEFAULT = 4;
    localparam int RUN_CNT_BITS        = 4;

endpackage

// File: rtl/dmem_arb_prio.sv
// ----------------------------------------------------------------------------
// dmem_arb_prio
//   Grant decision for the two memory requesters plus the CPU run counter.
//   The CPU wins by default. When the DMA port has watched MAX_CPU_RUN
//   consecutive CPU grants while it was waiting, the DMA port wins instead.
//
//   Ports
//     clk, rst   : clock, synchronous active-high reset
//     arb_en     : arbitration allowed this cycle (FSM idle, not in reset)
//     cpu_valid  : CPU request pending
//     dma_valid  : DMA request pending
//     grant_cpu  : CPU granted this cycle (combinational)
//     grant_dma  : DMA granted this cycle (combinational)
// ----------------------------------------------------------------------------
module dmem_arb_prio
    import dmem_arb_pkg::*;
#(
    parameter int MAX_CPU_RUN = MAX_CPU_RUN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic cpu_valid,
    input  logic dma_valid,
    output logic grant_cpu,
    output logic grant_dma
);

    localparam logic [RUN_CNT_BITS-1:0] RUN_MAX = RUN_CNT_BITS'(MAX_CPU_RUN);

    logic [RUN_CNT_BITS-1:0] run_cnt_q;
    logic [RUN_CNT_BITS-1:0] run_cnt_d;
    logic                    dma_due;

    always_comb begin
        // The DMA port becomes due once the CPU has used up its run.
        dma_due   = dma_valid && (run_cnt_q == RUN_MAX);
        grant_cpu = arb_en && cpu_valid && !dma_due;
        grant_dma = arb_en && dma_valid && !grant_cpu;
    end

    // The counter only tracks CPU grants taken while DMA is waiting.
    // Any cycle without a DMA request resets it, even in READ_WAIT.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (!dma_valid || grant_dma) begin
            run_cnt_d = '0;
        end else if (grant_cpu && (run_cnt_q != RUN_MAX)) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data_memory between the CPU MEM stage and a
//   DMA/debug port.
//   - A write completes in its grant cycle.
//   - A read takes the grant cycle plus one READ_WAIT cycle. The data is
//     returned on the owning port one cycle later, with a single-cycle
//     rsp_valid pulse.
//
//   State table
//     IDLE      | arbitrate; grant cycle for writes and for the read address
//     READ_WAIT | hold mem_read and the captured address; data captured at
//               | the edge that ends this state
//
//   Ports
//     clk, rst                         : clock, synchronous active-high reset
//     cpu_req_* / cpu_rsp_*            : CPU request/response port
//     dma_req_* / dma_rsp_*            : DMA/debug request/response port
//     mem_write, mem_read, mem_address,
//     mem_data_in, mem_data_out        : data_memory interface
// ----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int A_BITS      = `A_BITS,
    parameter int D_BITS      = `D_BITS,
    parameter int MAX_CPU_RUN = MAX_CPU_RUN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req_valid,
    input  logic              cpu_req_write,
    input  logic [A_BITS-1:0] cpu_req_addr,
    input  logic [D_BITS-1:0] cpu_req_wdata,
    output logic              cpu_req_ready,
    output logic              cpu_rsp_valid,
    output logic [D_BITS-1:0] cpu_rsp_rdata,

    input  logic              dma_req_valid,
    input  logic              dma_req_write,
    input  logic [A_BITS-1:0] dma_req_addr,
    input  logic [D_BITS-1:0] dma_req_wdata,
    output logic              dma_req_ready,
    output logic              dma_rsp_valid,
    output logic [D_BITS-1:0] dma_rsp_rdata,

    output logic              mem_write,
    output logic              mem_read,
    output logic [A_BITS-1:0] mem_address,
    output logic [D_BITS-1:0] mem_data_in,
    input  logic [D_BITS-1:0] mem_data_out
);

    arb_state_e        state_q;
    arb_port_e         rd_port_q;
    logic [A_BITS-1:0] rd_addr_q;
    logic              cpu_rsp_valid_q;
    logic              dma_rsp_valid_q;
    logic [D_BITS-1:0] cpu_rsp_rdata_q;
    logic [D_BITS-1:0] dma_rsp_rdata_q;

    logic              arb_en;
    logic              grant_cpu;
    logic              grant_dma;
    logic              grant_any;
    arb_port_e         gnt_port_d;
    logic              gnt_write_d;
    logic [A_BITS-1:0] gnt_addr_d;
    logic [D_BITS-1:0] gnt_wdata_d;

    assign arb_en = !rst && (state_q == IDLE);

    dmem_arb_prio #(
        .MAX_CPU_RUN (MAX_CPU_RUN)
    ) u_prio (
        .clk       (clk),
        .rst       (rst),
        .arb_en    (arb_en),
        .cpu_valid (cpu_req_valid),
        .dma_valid (dma_req_valid),
        .grant_cpu (grant_cpu),
        .grant_dma (grant_dma)
    );

    // Select the request of the granted port. Grants are one-hot, so
    // defaulting to the CPU fields when nothing is granted is harmless:
    // mem_write and mem_read stay low in that case.
    always_comb begin
        grant_any   = grant_cpu || grant_dma;
        gnt_port_d  = grant_dma ? PORT_DMA : PORT_CPU;
        gnt_write_d = grant_dma ? dma_req_write : cpu_req_write;
        gnt_addr_d  = grant_dma ? dma_req_addr  : cpu_req_addr;
        gnt_wdata_d = grant_dma ? dma_req_wdata : cpu_req_wdata;
    end

    always_comb begin
        cpu_req_ready = grant_cpu;
        dma_req_ready = grant_dma;
        mem_write     = grant_any && gnt_write_d;
        // In reset the READ_WAIT term is masked so the aborted read stops
        // driving memory straight away.
        mem_read      = (grant_any && !gnt_write_d) ||
                        (!rst && (state_q == READ_WAIT));
        mem_address   = (state_q == READ_WAIT) ? rd_addr_q : gnt_addr_d;
        mem_data_in   = gnt_wdata_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            rd_port_q       <= PORT_CPU;
            rd_addr_q       <= '0;
            cpu_rsp_valid_q <= 1'b0;
            dma_rsp_valid_q <= 1'b0;
            cpu_rsp_rdata_q <= '0;
            dma_rsp_rdata_q <= '0;
        end else begin
            cpu_rsp_valid_q <= 1'b0;
            dma_rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_any && !gnt_write_d) begin
                        state_q   <= READ_WAIT;
                        rd_addr_q <= gnt_addr_d;
                        rd_port_q <= gnt_port_d;
                    end
                end
                READ_WAIT: begin
                    state_q <= IDLE;
                    // Only the owning port's data register changes, so the
                    // other port keeps its last response.
                    if (rd_port_q == PORT_CPU) begin
                        cpu_rsp_valid_q <= 1'b1;
                        cpu_rsp_rdata_q <= mem_data_out;
                    end else begin
                        dma_rsp_valid_q <= 1'b1;
                        dma_rsp_rdata_q <= mem_data_out;
                    end
                end
            endcase
        end
    end

    assign cpu_rsp_valid = cpu_rsp_valid_q;
    assign cpu_rsp_rdata = cpu_rsp_rdata_q;
    assign dma_rsp_valid = dma_rsp_valid_q;
    assign dma_rsp_rdata = dma_rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Drives both ports and runs a behavioural model of the arbiter and of
//   memory contents alongside the DUT.
//   - Behavioural memory: a simple array that responds to mem_* pins.
//   - Each cycle, the grant, memory pins and responses are compared with
//     the model.
//   - Directed scenarios come first: reset, write/read-back, simultaneous
//     reads, starvation limit, reset mid-read and response routing.
//   - A randomized phase with occasional resets follows.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int MAXR = 4;

    logic          clk = 1'b0;
    logic          rst;

    logic          cpu_req_valid, cpu_req_write;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata;
    logic          cpu_req_ready, cpu_rsp_valid;
    logic [DW-1:0] cpu_rsp_rdata;

    logic          dma_req_valid, dma_req_write;
    logic [AW-1:0] dma_req_addr;
    logic [DW-1:0] dma_req_wdata;
    logic          dma_req_ready, dma_rsp_valid;
    logic [DW-1:0] dma_rsp_rdata;

    logic          mem_write, mem_read;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in, mem_data_out;

    logic [DW-1:0] sim_mem [0:(1<<AW)-1];
    int            ref_mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    // model state: busy = read in flight, port 0 = CPU / 1 = DMA
    int m_busy, m_port, m_addr, m_run;
    int e_cv, e_dv, e_cd, e_dd;
    int gnt_c, gnt_d;
    int rnd_mode;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .A_BITS      (AW),
        .D_BITS      (DW),
        .MAX_CPU_RUN (MAXR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_write (cpu_req_write),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_req_ready (cpu_req_ready),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_rdata (cpu_rsp_rdata),
        .dma_req_valid (dma_req_valid),
        .dma_req_write (dma_req_write),
        .dma_req_addr  (dma_req_addr),
        .dma_req_wdata (dma_req_wdata),
        .dma_req_ready (dma_req_ready),
        .dma_rsp_valid (dma_rsp_valid),
        .dma_rsp_rdata (dma_rsp_rdata),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .mem_address   (mem_address),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out)
    );

    always @(posedge clk) begin
        if (mem_write) sim_mem[mem_address] <= mem_data_in;
    end
    assign mem_data_out = sim_mem[mem_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Properties that must hold on every cycle of every test.
    always @(negedge clk) begin
        check("mem_rw_exclusive", {31'b0, mem_write & mem_read}, 32'd0);
        check("ready_exclusive",  {31'b0, cpu_req_ready & dma_req_ready}, 32'd0);
    end

    task automatic new_req(input int is_dma, input int wr, input int addr, input int data);
        if (is_dma != 0) begin
            dma_req_valid = 1'b1;
            dma_req_write = (wr != 0);
            dma_req_addr  = AW'(addr);
            dma_req_wdata = DW'(data);
        end else begin
            cpu_req_valid = 1'b1;
            cpu_req_write = (wr != 0);
            cpu_req_addr  = AW'(addr);
            cpu_req_wdata = DW'(data);
        end
    endtask

    // One clock cycle:
    //   1. Check the DUT outputs against the model at the negedge.
    //   2. Advance the model to the next posedge.
    //   3. Update the requesters just after that posedge.
    task automatic step();
        int gc, gd, ew, er, eaddr, edata, wr;
        @(negedge clk);
        gc = 0; gd = 0; ew = 0; er = 0; eaddr = 0; edata = 0; wr = 0;
        if (!rst) begin
            if (m_busy != 0) begin
                er    = 1;
                eaddr = m_addr;
            end else begin
                gc = (cpu_req_valid && !(dma_req_valid && m_run == MAXR)) ? 1 : 0;
                gd = (dma_req_valid && gc == 0) ? 1 : 0;
                if (gc + gd != 0) begin
                    wr    = (gc != 0) ? int'(cpu_req_write) : int'(dma_req_write);
                    eaddr = (gc != 0) ? int'(cpu_req_addr)  : int'(dma_req_addr);
                    edata = (gc != 0) ? int'(cpu_req_wdata) : int'(dma_req_wdata);
                    ew    = wr;
                    er    = 1 - wr;
                end
            end
        end
        check("cpu_req_ready", {31'b0, cpu_req_ready}, gc);
        check("dma_req_ready", {31'b0, dma_req_ready}, gd);
        check("mem_write", {31'b0, mem_write}, ew);
        check("mem_read",  {31'b0, mem_read},  er);
        if (ew + er != 0) check("mem_address", {24'b0, mem_address}, eaddr);
        if (ew != 0)      check("mem_data_in", {24'b0, mem_data_in}, edata);
        check("cpu_rsp_valid", {31'b0, cpu_rsp_valid}, e_cv);
        check("dma_rsp_valid", {31'b0, dma_rsp_valid}, e_dv);
        check("cpu_rsp_rdata", {24'b0, cpu_rsp_rdata}, e_cd);
        check("dma_rsp_rdata", {24'b0, dma_rsp_rdata}, e_dd);
        gnt_c = int'(cpu_req_ready);
        gnt_d = int'(dma_req_ready);

        e_cv = 0;
        e_dv = 0;
        if (rst) begin
            m_busy = 0; m_port = 0; m_addr = 0;
            e_cd = 0; e_dd = 0;
        end else if (m_busy != 0) begin
            m_busy = 0;
            if (m_port == 0) begin e_cv = 1; e_cd = ref_mem[m_addr]; end
            else             begin e_dv = 1; e_dd = ref_mem[m_addr]; end
        end else if (gc + gd != 0) begin
            if (ew != 0) ref_mem[eaddr] = edata;
            else begin m_busy = 1; m_port = gd; m_addr = eaddr; end
        end
        if (rst || !dma_req_valid || gd != 0) m_run = 0;
        else if (gc != 0 && m_run < MAXR)     m_run = m_run + 1;

        @(posedge clk);
        #1;
        if (gnt_c != 0) cpu_req_valid = 1'b0;
        if (gnt_d != 0) dma_req_valid = 1'b0;
        if (rnd_mode != 0) begin
            if (!cpu_req_valid && $urandom_range(0, 99) < 60)
                new_req(0, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 255));
            if (!dma_req_valid && $urandom_range(0, 99) < 45)
                new_req(1, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 255));
            rst = ($urandom_range(0, 299) == 0);
        end
    endtask

    initial begin
        int ncpu, dgnt_at, dpulses, cpulses;
        rst = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        dma_req_valid = 1'b0; dma_req_write = 1'b0; dma_req_addr = '0; dma_req_wdata = '0;
        m_busy = 0; m_port = 0; m_addr = 0; m_run = 0;
        e_cv = 0; e_dv = 0; e_cd = 0; e_dd = 0;
        gnt_c = 0; gnt_d = 0; rnd_mode = 0;

        // reset with requests pending: nothing may be granted
        new_req(0, 1, 1, 8'h11);
        new_req(1, 0, 2, 0);
        repeat (3) step();
        check("rst_no_cpu_grant", gnt_c, 0);
        check("rst_no_dma_grant", gnt_d, 0);
        check("rst_cpu_rdata", {24'b0, cpu_rsp_rdata}, 0);
        cpu_req_valid = 1'b0;
        dma_req_valid = 1'b0;
        rst = 1'b0;

        // fill the address range used by the later reads
        for (int a = 0; a < 32; a++) begin
            new_req(0, 1, a, $urandom_range(0, 255));
            step();
        end

        // CPU write then read-back, data at T+2
        new_req(0, 1, 5, 8'hA5);
        step();
        check("w5_cpu_grant", gnt_c, 1);
        new_req(0, 0, 5, 0);
        step();
        check("r5_cpu_grant", gnt_c, 1);
        step();
        check("r5_rsp_valid", {31'b0, cpu_rsp_valid}, 1);
        check("r5_rsp_rdata", {24'b0, cpu_rsp_rdata}, 8'hA5);

        // simultaneous reads: CPU first, DMA right after READ_WAIT
        new_req(0, 0, 5, 0);
        new_req(1, 0, 6, 0);
        step();
        check("sim_cpu_first", gnt_c, 1);
        check("sim_dma_waits", gnt_d, 0);
        step();
        check("sim_wait_no_dma", gnt_d, 0);
        step();
        check("sim_dma_next", gnt_d, 1);
        step();
        check("sim_dma_rsp", {31'b0, dma_rsp_valid}, 1);

        // starvation limit: DMA read held against a stream of CPU writes
        new_req(1, 0, 7, 0);
        ncpu = 0;
        dgnt_at = 0;
        for (int c = 1; c <= 8 && dgnt_at == 0; c++) begin
            if (!cpu_req_valid) new_req(0, 1, 20 + c, $urandom_range(0, 255));
            step();
            if (gnt_c != 0) ncpu++;
            if (gnt_d != 0) dgnt_at = c;
        end
        check("starve_cpu_grants", ncpu, 4);
        check("starve_dma_cycle", dgnt_at, 5);
        check("starve_run_cnt", {28'b0, dut.u_prio.run_cnt_q}, 0);
        cpu_req_valid = 1'b0;
        step();
        step();

        // reset during READ_WAIT aborts the read
        new_req(0, 0, 3, 0);
        step();
        check("abort_read_grant", gnt_c, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_no_rsp", {31'b0, cpu_rsp_valid}, 0);
        new_req(0, 1, 4, 8'h11);
        step();
        check("post_rst_grant", gnt_c, 1);
        check("post_rst_no_rsp", {31'b0, cpu_rsp_valid}, 0);

        // response routing to the DMA port only
        new_req(1, 1, 9, 8'h3C);
        step();
        new_req(1, 0, 9, 0);
        dpulses = 0;
        cpulses = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (dma_rsp_valid) dpulses++;
            if (cpu_rsp_valid) cpulses++;
            if (dma_rsp_valid) check("route_dma_rdata", {24'b0, dma_rsp_rdata}, 8'h3C);
        end
        check("route_dma_pulses", dpulses, 1);
        check("route_cpu_pulses", cpulses, 0);
        check("route_cpu_rdata_kept", {24'b0, cpu_rsp_rdata}, 0);

        // randomized traffic with occasional resets
        rnd_mode = 1;
        repeat (2000) step();
        rnd_mode = 0;
        rst = 1'b0;
        cpu_req_valid = 1'b0;
        dma_req_valid = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
